scan_alert_blocklist: RTL and testbench
=======================================

Name: scan_alert_blocklist

Overview:
- Downstream consumer of the port-scan detector.
- Takes the detector's alert pulse/level with the offending IP, MAC and port, and records the IP in a small blocklist whose entries time out.
- Answers single-cycle IP lookups from the forwarding/drop stage.
- Queues one event record per newly blocked IP for the host/UART reporting path.

Parameters:
DEPTH, 8, number of blocklist entries (power of 2, 2..16)
TICK_CYCLES, 50_000_000, clock cycles per aging tick (1 s at 50 MHz)
TTL_TICKS, 60, lifetime of an entry in ticks, reloaded on refresh (1..255)
FIFO_DEPTH, 4, event FIFO depth (power of 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active high
alert_in  in  1  detector alert; a new alert is its 0->1 edge
ip_in  in  32  offending source IP, valid on the alert_in rising-edge cycle
mac_in  in  48  offending source MAC, valid with ip_in
port_in  in  16  port that triggered the alert, valid with ip_in
query_valid  in  1  lookup request strobe
query_ip  in  32  IP to look up
resp_valid  out  1  lookup result valid, 1 cycle after query_valid
resp_block  out  1  1 = query_ip is in a valid entry
evt_valid  out  1  event FIFO not empty
evt_ip  out  32  head event IP
evt_mac  out  48  head event MAC
evt_port  out  16  head event port
evt_ready  in  1  pop head when evt_valid & evt_ready
block_count  out  5  number of valid entries
drop_count  out  8  saturating count of alert edges lost while busy
evt_overflow  out  1  sticky; an event was lost because the FIFO was full

Behaviour:
Interface:
- One clock, clk.
- Reset rst is synchronous and active high.
- All outputs are registered.

Reset:
- All entries invalid, TTLs 0, FIFO empty.
- resp_valid, resp_block, evt_valid, evt_overflow = 0.
- block_count = 0, drop_count = 0, evt_* data = 0.
- FSM goes to IDLE, tick counter = 0, replace pointer = 0, alert edge register = 0.
- Reset mid-search abandons the pending insert.

Edge detect:
- alert_d registers alert_in every cycle.
- new_alert = alert_in & ~alert_d.

FSM (IDLE, SEARCH, UPDATE, LOG):
- IDLE: on new_alert, latch ip_in/mac_in/port_in, clear hit/free flags, idx = 0, go to SEARCH.
- SEARCH: examine one entry per cycle at idx.
  - Record the first valid entry whose IP matches (hit).
  - Record the first invalid entry (free).
  - Go to UPDATE after idx = DEPTH-1, i.e. DEPTH cycles.
- UPDATE:
  - On hit: reload that entry's TTL to TTL_TICKS, then go to IDLE with no event.
  - Else, if a free entry exists: write to it.
  - Else: overwrite the entry at the replace pointer and advance the pointer modulo DEPTH.
  - A write stores the IP, sets valid, sets TTL = TTL_TICKS, then goes to LOG.
- LOG:
  - Push {ip, mac, port} if the FIFO is not full.
  - If full, set evt_overflow instead.
  - Then go to IDLE.
- A new_alert outside IDLE increments drop_count, saturating at 255.
- Insert latency from the alert edge to the entry becoming valid is DEPTH+2 cycles.

Aging:
- The tick counter counts 0..TICK_CYCLES-1; the wrap cycle is the tick.
- On a tick, every valid entry with TTL > 0 decrements.
- An entry whose TTL decrements from 1 to 0 is invalidated in the same write.
- If a tick coincides with an UPDATE write to the same entry, the write wins (TTL = TTL_TICKS).

Lookup:
- query_valid compares query_ip against all valid entries in parallel.
- resp_valid pulses the next cycle, with resp_block = OR of matches.
- A lookup sees table state as it was before any same-cycle write.
- A lookup is accepted every cycle and is independent of the FSM.
- IP 0.0.0.0 is never stored: an alert with ip_in = 0 is ignored without counting as a drop. Lookups of 0 return resp_block = 0.

FIFO:
- First-word fall-through: evt_* show the head whenever evt_valid = 1.
- A push and a pop in the same cycle are both performed, including when full, since the pop frees a slot.

block_count:
- Updated the cycle after any valid-bit change.

Test Plan:
- Alert edge ip=C0A80105 mac=001122334455 port=0016 -> after 10 cycles (DEPTH=8) block_count=1; query C0A80105 -> resp_block=1; evt_ip=C0A80105, evt_port=0016, evt_valid=1 until popped.
- Same IP alerted again after 5 ticks (TTL_TICKS=60) -> no new event, TTL=60, block_count stays 1.
- TICK_CYCLES=10, TTL_TICKS=3, one insert -> entry invalid exactly 3 ticks later; query then returns resp_block=0; block_count=0.
- 9 distinct IPs with DEPTH=8, no pops, FIFO_DEPTH=4 -> 9th IP overwrites entry 0, first IP lookup=0; evt_overflow=1 after the 5th event.
- Second alert edge 3 cycles after the first -> drop_count=1, only the first IP stored; alert_in held high for 100 cycles -> a single insert.
- rst asserted during SEARCH -> all outputs at reset values next cycle, entry not written.

Source files
------------

// File: rtl/scan_alert_blocklist.sv
// Blocklist fed by the port-scan detector: inserts offending IPs into an aging
// table, answers single-cycle lookups, and queues one event per new block.
//
// state  | meaning
// IDLE   | waiting for a new alert edge
// SEARCH | walking the table one entry per cycle looking for a hit / free slot
// UPDATE | writing (or refreshing) the chosen entry
// LOG    | pushing the event record for a newly blocked IP
module scan_alert_blocklist #(
    parameter int DEPTH       = 8,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int TTL_TICKS   = 60,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alert_in,
    input  logic [31:0] ip_in,
    input  logic [47:0] mac_in,
    input  logic [15:0] port_in,
    input  logic        query_valid,
    input  logic [31:0] query_ip,
    output logic        resp_valid,
    output logic        resp_block,
    output logic        evt_valid,
    output logic [31:0] evt_ip,
    output logic [47:0] evt_mac,
    output logic [15:0] evt_port,
    input  logic        evt_ready,
    output logic [4:0]  block_count,
    output logic [7:0]  drop_count,
    output logic        evt_overflow
);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW  = $clog2(TICK_CYCLES + 1);
    localparam int FW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = FW + 1;

    typedef enum logic [1:0] {IDLE, SEARCH, UPDATE, LOG} state_t;

    state_t          state_q, state_d;
    logic            alert_d_q;
    logic            new_alert;
    logic [IW-1:0]   idx_q, hit_idx_q, free_idx_q, rep_ptr_q, tab_idx;
    logic            hit_q, free_q;
    logic [31:0]     ip_q;
    logic [47:0]     mac_q;
    logic [15:0]     port_q;
    logic            latch_en, tab_wr, rep_adv, log_en, drop_inc;
    logic            valid_q [DEPTH];
    logic [31:0]     ip_tab_q [DEPTH];
    logic [7:0]      ttl_q [DEPTH];
    logic [TW-1:0]   tick_cnt_q;
    logic            tick;
    logic            match_any;
    logic [4:0]      valid_cnt;
    logic [95:0]     mem_q [FIFO_DEPTH];
    logic [FW-1:0]   rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
    logic [FCW-1:0]  cnt_q, cnt_d;
    logic            push, pop;
    logic [95:0]     head_d, evt_word_q;
    logic            resp_valid_q, resp_block_q, evt_valid_q, ovf_q;
    logic [4:0]      block_count_q;
    logic [7:0]      drop_count_q;

    // Zero IP is never blocked, so such alerts are invisible to the FSM and drop counter.
    assign new_alert = alert_in & ~alert_d_q & (ip_in != 32'd0);
    assign tick      = (tick_cnt_q == TW'(TICK_CYCLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_d  = state_q;
        latch_en = 1'b0;
        tab_wr   = 1'b0;
        tab_idx  = hit_idx_q;
        rep_adv  = 1'b0;
        log_en   = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (new_alert) begin
                    latch_en = 1'b1;
                    state_d  = SEARCH;
                end
            end
            SEARCH: begin
                drop_inc = new_alert;
                if (idx_q == IW'(DEPTH - 1)) state_d = UPDATE;
            end
            UPDATE: begin
                drop_inc = new_alert;
                tab_wr   = 1'b1;
                if (hit_q) begin
                    state_d = IDLE;
                end else begin
                    if (free_q) begin
                        tab_idx = free_idx_q;
                    end else begin
                        tab_idx = rep_ptr_q;
                        rep_adv = 1'b1;
                    end
                    state_d = LOG;
                end
            end
            LOG: begin
                drop_inc = new_alert;
                log_en   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Alert capture and the sequential table walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            alert_d_q  <= 1'b0;
            idx_q      <= '0;
            hit_q      <= 1'b0;
            free_q     <= 1'b0;
            hit_idx_q  <= '0;
            free_idx_q <= '0;
            ip_q       <= '0;
            mac_q      <= '0;
            port_q     <= '0;
            rep_ptr_q  <= '0;
        end else begin
            alert_d_q <= alert_in;
            if (rep_adv) rep_ptr_q <= rep_ptr_q + 1'b1;
            if (latch_en) begin
                ip_q   <= ip_in;
                mac_q  <= mac_in;
                port_q <= port_in;
                hit_q  <= 1'b0;
                free_q <= 1'b0;
                idx_q  <= '0;
            end else if (state_q == SEARCH) begin
                idx_q <= idx_q + 1'b1;
                if (!hit_q && valid_q[idx_q] && (ip_tab_q[idx_q] == ip_q)) begin
                    hit_q     <= 1'b1;
                    hit_idx_q <= idx_q;
                end
                if (!free_q && !valid_q[idx_q]) begin
                    free_q     <= 1'b1;
                    free_idx_q <= idx_q;
                end
            end
        end
    end

    // Aging tick generator.
    always_ff @(posedge clk) begin
        if (rst)       tick_cnt_q <= '0;
        else if (tick) tick_cnt_q <= '0;
        else           tick_cnt_q <= tick_cnt_q + 1'b1;
    end

    // Table entries: an UPDATE write overrides a coincident aging decrement.
    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (rst) begin
                valid_q[e]  <= 1'b0;
                ip_tab_q[e] <= '0;
                ttl_q[e]    <= '0;
            end else if (tab_wr && (tab_idx == IW'(e))) begin
                valid_q[e]  <= 1'b1;
                ip_tab_q[e] <= ip_q;
                ttl_q[e]    <= 8'(TTL_TICKS);
            end else if (tick && valid_q[e] && (ttl_q[e] != 8'd0)) begin
                ttl_q[e] <= ttl_q[e] - 8'd1;
                if (ttl_q[e] == 8'd1) valid_q[e] <= 1'b0;
            end
        end
    end

    // Parallel lookup match and occupancy count over the pre-write table.
    always_comb begin
        match_any = 1'b0;
        valid_cnt = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (valid_q[e] && (ip_tab_q[e] == query_ip)) match_any = 1'b1;
            valid_cnt = valid_cnt + 5'(valid_q[e]);
        end
    end

    // Lookup response, occupancy, and drop counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q  <= 1'b0;
            resp_block_q  <= 1'b0;
            block_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            resp_valid_q  <= query_valid;
            resp_block_q  <= query_valid && match_any && (query_ip != 32'd0);
            block_count_q <= valid_cnt;
            if (drop_inc && (drop_count_q != 8'hFF)) drop_count_q <= drop_count_q + 8'd1;
        end
    end

    // FIFO pointer arithmetic and next head word (fall-through when empty).
    always_comb begin
        pop      = evt_valid_q & evt_ready;
        push     = log_en & ((cnt_q != FCW'(FIFO_DEPTH)) | pop);
        rd_ptr_d = rd_ptr_q + FW'(pop);
        wr_ptr_d = wr_ptr_q + FW'(push);
        cnt_d    = cnt_q + FCW'(push) - FCW'(pop);
        if (push && (rd_ptr_d == wr_ptr_q)) head_d = {ip_q, mac_q, port_q};
        else                                head_d = mem_q[rd_ptr_d];
    end

    // Event FIFO storage, registered head, and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_word_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= {ip_q, mac_q, port_q};
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            evt_valid_q <= (cnt_d != '0);
            evt_word_q  <= head_d;
            if (log_en && !push) ovf_q <= 1'b1;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_block   = resp_block_q;
    assign evt_valid    = evt_valid_q;
    assign evt_ip       = evt_word_q[95:64];
    assign evt_mac      = evt_word_q[63:16];
    assign evt_port     = evt_word_q[15:0];
    assign block_count  = block_count_q;
    assign drop_count   = drop_count_q;
    assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_scan_alert_blocklist.sv
// Self-checking bench for scan_alert_blocklist: directed scenarios plus
// randomized traffic against a table model built from write times and tick counts.
module tb_scan_alert_blocklist;
    localparam int DEPTH = 8;
    localparam int TC    = 16;
    localparam int TTL   = 8;
    localparam int FD    = 4;

    logic        clk, rst, alert_in, query_valid, evt_ready;
    logic [31:0] ip_in, query_ip;
    logic [47:0] mac_in;
    logic [15:0] port_in;
    logic        resp_valid, resp_block, evt_valid, evt_overflow;
    logic [31:0] evt_ip;
    logic [47:0] evt_mac;
    logic [15:0] evt_port;
    logic [4:0]  block_count;
    logic [7:0]  drop_count;

    scan_alert_blocklist #(.DEPTH(DEPTH), .TICK_CYCLES(TC), .TTL_TICKS(TTL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .alert_in(alert_in), .ip_in(ip_in), .mac_in(mac_in),
        .port_in(port_in), .query_valid(query_valid), .query_ip(query_ip),
        .resp_valid(resp_valid), .resp_block(resp_block), .evt_valid(evt_valid),
        .evt_ip(evt_ip), .evt_mac(evt_mac), .evt_port(evt_port), .evt_ready(evt_ready),
        .block_count(block_count), .drop_count(drop_count), .evt_overflow(evt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ip;
        logic [47:0] mac;
        logic [15:0] port;
    } ev_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: each entry remembers the edge it was last written on;
    // validity follows from how many ticks have passed since then.
    int          x;
    int          m_w [DEPTH];
    logic [31:0] m_ip [DEPTH];
    int          idle_at, pend_w, pend_idx, log_at, rep_ptr, drops;
    logic [31:0] pend_ip;
    ev_t         pend_ev;
    ev_t         evq[$];
    bit          prev_alert, ovf;
    logic [31:0] pool [13];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, x);
        end
    endtask

    // Entry e valid in the table as it stands after edge xe.
    function automatic bit vld(input int e, input int xe);
        return (m_w[e] >= 0) && (xe >= m_w[e]) && ((xe / TC) - (m_w[e] / TC) < TTL);
    endfunction

    task automatic model_reset();
        x = 0; idle_at = 0; pend_w = -1; pend_idx = 0; log_at = -1; rep_ptr = 0;
        drops = 0; ovf = 0; prev_alert = 0; pend_ip = '0;
        evq.delete();
        for (int e = 0; e < DEPTH; e++) begin
            m_w[e] = -1;
            m_ip[e] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; alert_in = 1'b0; query_valid = 1'b0; evt_ready = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_block", resp_block, 0);
        chk("rst_evt_valid", evt_valid, 0);
        chk("rst_evt_ip", evt_ip, 0);
        chk("rst_evt_mac", evt_mac, 0);
        chk("rst_evt_port", evt_port, 0);
        chk("rst_block_count", block_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_overflow", evt_overflow, 0);
        rst = 1'b0;
    endtask

    task automatic step();
        bit exp_rv, exp_rb, na, hit, fre, pop;
        int bc, hidx, fidx;
        @(posedge clk);
        x++;
        exp_rv = query_valid;
        exp_rb = 0;
        bc = 0;
        for (int e = 0; e < DEPTH; e++) begin
            if (query_valid && (query_ip != 0) && vld(e, x - 1) && (m_ip[e] == query_ip)) exp_rb = 1;
            if (vld(e, x - 1)) bc++;
        end
        na = alert_in && !prev_alert && (ip_in != 0);
        prev_alert = alert_in;
        if (na) begin
            if (x >= idle_at) begin
                hit = 0; fre = 0; hidx = 0; fidx = 0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (!hit && vld(i, x + i) && (m_ip[i] == ip_in)) begin hit = 1; hidx = i; end
                    if (!fre && !vld(i, x + i)) begin fre = 1; fidx = i; end
                end
                pend_ip = ip_in;
                pend_w  = x + DEPTH + 1;
                if (hit) begin
                    pend_idx = hidx;
                    idle_at  = x + DEPTH + 2;
                    log_at   = -1;
                end else begin
                    if (fre) pend_idx = fidx;
                    else begin
                        pend_idx = rep_ptr;
                        rep_ptr  = (rep_ptr + 1) % DEPTH;
                    end
                    idle_at = x + DEPTH + 3;
                    log_at  = x + DEPTH + 2;
                    pend_ev = '{ip: ip_in, mac: mac_in, port: port_in};
                end
            end else if (drops < 255) drops++;
        end
        if (x == pend_w) begin
            m_ip[pend_idx] = pend_ip;
            m_w[pend_idx]  = x;
            pend_w = -1;
        end
        pop = (evq.size() > 0) && evt_ready;
        if (pop) void'(evq.pop_front());
        if (x == log_at) begin
            if (evq.size() < FD) evq.push_back(pend_ev);
            else ovf = 1;
        end
        #1;
        chk("resp_valid", resp_valid, exp_rv);
        chk("resp_block", resp_block, exp_rb);
        chk("evt_valid", evt_valid, evq.size() > 0);
        if (evq.size() > 0) begin
            chk("evt_ip", evt_ip, evq[0].ip);
            chk("evt_mac", evt_mac, evq[0].mac);
            chk("evt_port", evt_port, evq[0].port);
        end
        chk("block_count", block_count, bc);
        chk("drop_count", drop_count, drops);
        chk("evt_overflow", evt_overflow, ovf);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic alert_pulse(input logic [31:0] ip, input logic [47:0] mac, input logic [15:0] port);
        alert_in = 1'b1; ip_in = ip; mac_in = mac; port_in = port;
        step();
        alert_in = 1'b0;
    endtask

    task automatic query_once(input logic [31:0] ip, input string tag, input logic exp);
        query_valid = 1'b1; query_ip = ip;
        step();
        chk(tag, resp_block, exp);
        query_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] r64;
        rst = 1'b1; alert_in = 1'b0; ip_in = '0; mac_in = '0; port_in = '0;
        query_valid = 1'b0; query_ip = '0; evt_ready = 1'b0;
        pool[0] = 32'h0;
        for (int i = 1; i < 13; i++) pool[i] = 32'hC0A80100 + i;
        model_reset();

        // Single insert, lookup, event, then refresh of the same IP.
        do_reset();
        alert_pulse(32'hC0A80105, 48'h001122334455, 16'h0016);
        steps(9);
        chk("ins_bc_early", block_count, 0);
        step();
        chk("ins_bc", block_count, 1);
        query_once(32'hC0A80105, "ins_query", 1'b1);
        chk("ins_evt_ip", evt_ip, 32'hC0A80105);
        chk("ins_evt_port", evt_port, 16'h0016);
        query_once(32'h0, "query_zero", 1'b0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("ins_popped", evt_valid, 0);
        while (x < 83) step();
        alert_pulse(32'hC0A80105, 48'h001122334455, 16'h0016);
        steps(11);
        chk("refresh_no_evt", evt_valid, 0);
        chk("refresh_bc", block_count, 1);
        while (x < 149) step();
        query_once(32'hC0A80105, "refresh_alive", 1'b1);
        while (x < 214) step();
        query_once(32'hC0A80105, "expired_query", 1'b0);
        chk("expired_bc", block_count, 0);

        // Alert while busy is dropped; a held alert inserts once.
        do_reset();
        alert_pulse(32'h0A0A0A01, 48'h1, 16'h1);
        step();
        alert_pulse(32'h0A0A0A02, 48'h2, 16'h2);
        steps(12);
        chk("drop_one", drop_count, 1);
        alert_in = 1'b1; ip_in = 32'h0A0A0A03;
        steps(100);
        alert_in = 1'b0;
        steps(3);
        chk("held_bc", block_count, 2);
        chk("held_drop", drop_count, 1);
        query_once(32'h0A0A0A02, "dropped_ip", 1'b0);

        // Reset in the middle of a search abandons the insert.
        do_reset();
        alert_pulse(32'h0B0B0B0B, 48'h3, 16'h3);
        steps(3);
        do_reset();
        steps(15);
        chk("abort_bc", block_count, 0);
        chk("abort_evt", evt_valid, 0);

        // Nine distinct IPs: ninth overwrites entry 0, fifth event overflows.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            alert_pulse(32'h0A000001 + k, 48'(k), 16'(k));
            steps(11);
            if (k == 3) chk("ovf_before", evt_overflow, 0);
        end
        chk("ovf_after", evt_overflow, 1);
        query_once(32'h0A000001, "ovw_first", 1'b0);
        query_once(32'h0A000009, "ovw_ninth", 1'b1);
        query_once(32'h0A000002, "ovw_second", 1'b1);
        chk("ovw_bc", block_count, 8);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            alert_in    = ($urandom_range(0, 5) == 0);
            ip_in       = pool[$urandom_range(0, 12)];
            r64         = {$urandom, $urandom};
            mac_in      = r64[47:0];
            port_in     = 16'($urandom);
            query_valid = $urandom_range(0, 1);
            query_ip    = pool[$urandom_range(0, 12)];
            evt_ready   = ($urandom_range(0, 9) < 3);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
